sobel_edge: RTL



---
 rtl/vga_pkg.sv | 7 +
 rtl/sobel_kernel.sv | 78 +++++++
 rtl/sobel_edge.sv | 110 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants for the VGA pixel pipeline
package vga_pkg;
    localparam int         PIX_W     = 8;
    localparam int         GRAD_W    = 11;
    localparam int         SOBEL_LAT = 3;
    localparam logic [7:0] THR_RESET = 8'd128;
endpackage

// File: rtl/sobel_kernel.sv
// rtl/sobel_kernel.sv - 3-stage Sobel arithmetic: weighted sums, abs, magnitude, saturate, compare
//
// Ports:
//   pclk, rst        pixel clock, asynchronous active-high reset
//   p11..p33         window pixels, p<row><col>; row 1 oldest, col 1 newest
//   thr              active threshold applied at stage 3
//   keep             pixel-valid-and-not-border, aligned with the stage-2 registers
//   mag              min(|Gx|+|Gy|, 2^PW-1), zero when keep was low
//   edge_px          all-ones when the full magnitude >= thr, zero when keep was low
module sobel_kernel
    import vga_pkg::*;
#(
    parameter int PW = PIX_W
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic [PW-1:0] p11,
    input  logic [PW-1:0] p12,
    input  logic [PW-1:0] p13,
    input  logic [PW-1:0] p21,
    input  logic [PW-1:0] p23,
    input  logic [PW-1:0] p31,
    input  logic [PW-1:0] p32,
    input  logic [PW-1:0] p33,
    input  logic [PW-1:0] thr,
    input  logic          keep,
    output logic [PW-1:0] mag,
    output logic [PW-1:0] edge_px
);
    localparam int SW = PW + 2;   // a + 2b + c
    localparam int GW = PW + 3;   // signed difference of two sums

    function automatic logic [SW-1:0] wsum(input logic [PW-1:0] a,
                                           input logic [PW-1:0] b,
                                           input logic [PW-1:0] c);
        return SW'(a) + SW'({b, 1'b0}) + SW'(c);
    endfunction

    logic [SW-1:0] sx_l, sx_r, sy_b, sy_t;
    logic [GW-1:0] ax, ay;

    logic signed [GW-1:0] gx, gy;
    logic [GW-1:0]        m;

    assign gx = $signed({1'b0, sx_l}) - $signed({1'b0, sx_r});
    assign gy = $signed({1'b0, sy_b}) - $signed({1'b0, sy_t});
    assign m  = ax + ay;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            sx_l    <= '0;
            sx_r    <= '0;
            sy_b    <= '0;
            sy_t    <= '0;
            ax      <= '0;
            ay      <= '0;
            mag     <= '0;
            edge_px <= '0;
        end else begin
            // stage 1: column sums for Gx, row sums for Gy
            sx_l <= wsum(p11, p21, p31);
            sx_r <= wsum(p13, p23, p33);
            sy_b <= wsum(p31, p32, p33);
            sy_t <= wsum(p11, p12, p13);
            // stage 2: absolute gradients
            ax <= gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
            ay <= gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
            // stage 3: compare uses the unsaturated magnitude
            if (keep) begin
                mag     <= (|m[GW-1:PW]) ? '1 : m[PW-1:0];
                edge_px <= (m >= GW'(thr)) ? '1 : '0;
            end else begin
                mag     <= '0;
                edge_px <= '0;
            end
        end
    end
endmodule

// File: rtl/sobel_edge.sv
// rtl/sobel_edge.sv - Sobel edge detector on a 3x3 window with border suppression and sync delay
//
// Ports:
//   pclk, rst                       pixel clock, asynchronous active-high reset
//   line11_data..line33_data        window pixels, lineRC; R=1 oldest row, C=1 newest column
//   de_flag_line, hsync_line,
//   vsync_line                      controls aligned with the window
//   threshold                       edge threshold, sampled into thr_act during vsync
//   mag_sobel                       saturated gradient magnitude
//   data_sobel                      8'hFF edge / 8'h00 no edge
//   de_flag_sobel, hsync_sobel,
//   vsync_sobel                     controls delayed by SOBEL_LAT cycles
module sobel_edge
    import vga_pkg::*;
#(
    parameter logic VS_ACTIVE = 1'b0,
    parameter int   COL_W     = 11,
    parameter int   ROW_W     = 10
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [PIX_W-1:0] line11_data,
    input  logic [PIX_W-1:0] line12_data,
    input  logic [PIX_W-1:0] line13_data,
    input  logic [PIX_W-1:0] line21_data,
    input  logic [PIX_W-1:0] line22_data,
    input  logic [PIX_W-1:0] line23_data,
    input  logic [PIX_W-1:0] line31_data,
    input  logic [PIX_W-1:0] line32_data,
    input  logic [PIX_W-1:0] line33_data,
    input  logic             de_flag_line,
    input  logic             hsync_line,
    input  logic             vsync_line,
    input  logic [PIX_W-1:0] threshold,
    output logic [PIX_W-1:0] mag_sobel,
    output logic [PIX_W-1:0] data_sobel,
    output logic             de_flag_sobel,
    output logic             hsync_sobel,
    output logic             vsync_sobel
);
    logic [COL_W-1:0]     col_cnt;
    logic [ROW_W-1:0]     row_cnt;
    logic                 de_d;
    logic [PIX_W-1:0]     thr_act;
    logic [SOBEL_LAT-1:0] de_p, hs_p, vs_p;
    logic [SOBEL_LAT-2:0] keep_p;

    logic vs_on, de_fall, border;

    assign vs_on   = (vsync_line == VS_ACTIVE);
    assign de_fall = de_d & ~de_flag_line;
    // col_cnt holds the index of the pixel being accepted (cleared while de is low),
    // so indices 0 and 1 of each line and rows 0 and 1 of each frame hold stale data.
    assign border  = (col_cnt < COL_W'(2)) || (row_cnt < ROW_W'(2));

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
            de_d    <= 1'b0;
            thr_act <= THR_RESET;
            de_p    <= '0;
            hs_p    <= '0;
            vs_p    <= '0;
            keep_p  <= '0;
        end else begin
            de_d <= de_flag_line;

            if (!de_flag_line)
                col_cnt <= '0;
            else if (col_cnt != '1)
                col_cnt <= col_cnt + COL_W'(1);

            // vsync clear takes priority over a same-cycle line end
            if (vs_on)
                row_cnt <= '0;
            else if (de_fall && row_cnt != '1)
                row_cnt <= row_cnt + ROW_W'(1);

            if (vs_on)
                thr_act <= threshold;

            de_p   <= {de_p[SOBEL_LAT-2:0], de_flag_line};
            hs_p   <= {hs_p[SOBEL_LAT-2:0], hsync_line};
            vs_p   <= {vs_p[SOBEL_LAT-2:0], vsync_line};
            keep_p <= {keep_p[SOBEL_LAT-3:0], de_flag_line & ~border};
        end
    end

    assign de_flag_sobel = de_p[SOBEL_LAT-1];
    assign hsync_sobel   = hs_p[SOBEL_LAT-1];
    assign vsync_sobel   = vs_p[SOBEL_LAT-1];

    sobel_kernel #(.PW(PIX_W)) u_kernel (
        .pclk    (pclk),
        .rst     (rst),
        .p11     (line11_data),
        .p12     (line12_data),
        .p13     (line13_data),
        .p21     (line21_data),
        .p23     (line23_data),
        .p31     (line31_data),
        .p32     (line32_data),
        .p33     (line33_data),
        .thr     (thr_act),
        .keep    (keep_p[SOBEL_LAT-2]),
        .mag     (mag_sobel),
        .edge_px (data_sobel)
    );
endmodule
